// File: rtl/regfile_dbg_master_if.sv
// Purpose: bundle between the debug master, the register-file port mux and the debug transport.
// Latency: wires only, no state.
// Backpressure: out_valid/out_ready on the dump stream; bus_req/bus_gnt for port ownership.
interface regfile_dbg_master_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // register-file port ownership
  logic          bus_req;
  logic          bus_gnt;
  // register-file ports
  logic          chip_en;
  logic          write_enable;
  logic [AW-1:0] wr_port_add;
  logic [DW-1:0] wr_port_data;
  logic [AW-1:0] rs1_address;
  logic [DW-1:0] rs1_data;
  // write command from the debug host
  logic          cmd_wr;
  logic [AW-1:0] cmd_wr_addr;
  logic [DW-1:0] cmd_wr_data;
  logic          wr_ack;
  logic          wr_err;
  // dump command and output stream
  logic          cmd_dump;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          dump_done;
  logic [DW-1:0] dump_sum;
  logic          busy;

  // view of the debug master itself
  modport master (
    output bus_req,
    input  bus_gnt,
    output chip_en,
    output write_enable,
    output wr_port_add,
    output wr_port_data,
    output rs1_address,
    input  rs1_data,
    input  cmd_wr,
    input  cmd_wr_addr,
    input  cmd_wr_data,
    output wr_ack,
    output wr_err,
    input  cmd_dump,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data,
    output dump_done,
    output dump_sum,
    output busy
  );

  // view of the surroundings (port mux, register file, debug transport)
  modport slave (
    input  bus_req,
    output bus_gnt,
    input  chip_en,
    input  write_enable,
    input  wr_port_add,
    input  wr_port_data,
    input  rs1_address,
    output rs1_data,
    output cmd_wr,
    output cmd_wr_addr,
    output cmd_wr_data,
    input  wr_ack,
    input  wr_err,
    output cmd_dump,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data,
    input  dump_done,
    input  dump_sum,
    input  busy
  );
endinterface

// File: rtl/regfile_dbg_master.sv
// Purpose: debug initiator for the register file: single writes and full-file dumps with XOR checksum.
// Latency: write acks 3 cycles after cmd_wr; first dump word 3 cycles after cmd_dump, then 1 word per 2 cycles.
// Backpressure: dump words held stable until out_ready; lost bus_gnt stalls WRITE/LOAD without port activity.
module regfile_dbg_master #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_dbg_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_ACK,
    S_LOAD,
    S_HOLD,
    S_DONE
  } state_t;

  typedef enum logic {
    OP_WR,
    OP_DUMP
  } op_t;

  // index of the final register swept by a dump
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_q;
  op_t           op_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;
  logic [DW-1:0] sum_d;

  logic          bus_req_q;
  logic          wr_ack_q;
  logic          wr_err_q;
  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;
  logic          dump_done_q;
  logic [DW-1:0] dump_sum_q;
  logic          busy_q;

  logic          wr_nonzero;
  logic          port_active;

  // x0 is hardwired zero: writes to it are acknowledged with an error and never strobed
  assign wr_nonzero  = (wr_addr_q != '0);

  // the register-file ports are only touched in a port-using state while the mux selects us
  assign port_active = bus.bus_gnt && ((state_q == S_WRITE) || (state_q == S_LOAD));

  assign idx_d       = idx_q + AW'(1);
  assign sum_d       = dump_sum_q ^ bus.rs1_data;

  // register-file port drive; strobes gated by the live grant, addresses/data from latches
  assign bus.chip_en      = port_active;
  assign bus.write_enable = port_active && (state_q == S_WRITE) && wr_nonzero;
  assign bus.wr_port_add  = wr_addr_q;
  assign bus.wr_port_data = wr_data_q;
  assign bus.rs1_address  = idx_q;

  // registered handshake and stream outputs
  assign bus.bus_req   = bus_req_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.dump_done = dump_done_q;
  assign bus.dump_sum  = dump_sum_q;
  assign bus.busy      = busy_q;

  // command sequencing FSM with all handshake/stream outputs registered alongside the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      idx_q       <= '0;
      bus_req_q   <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      dump_done_q <= 1'b0;
      dump_sum_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // completion indications are single-cycle pulses
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      dump_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // a write beats a simultaneous dump; the dump request is simply dropped
          if (bus.cmd_wr) begin
            wr_addr_q <= bus.cmd_wr_addr;
            wr_data_q <= bus.cmd_wr_data;
            op_q      <= OP_WR;
            state_q   <= S_REQ;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (bus.cmd_dump) begin
            idx_q      <= '0;
            dump_sum_q <= '0;
            op_q       <= OP_DUMP;
            state_q    <= S_REQ;
            bus_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus.bus_gnt) begin
            state_q <= (op_q == OP_WR) ? S_WRITE : S_LOAD;
          end
        end

        S_WRITE: begin
          // the strobe happens combinationally this cycle; wait here if the grant was lost
          if (bus.bus_gnt) begin
            state_q   <= S_ACK;
            wr_ack_q  <= 1'b1;
            wr_err_q  <= !wr_nonzero;
            bus_req_q <= 1'b0;
          end
        end

        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        S_LOAD: begin
          // capture only while granted so rs1_data really reflects our address
          if (bus.bus_gnt) begin
            out_data_q  <= bus.rs1_data;
            out_addr_q  <= idx_q;
            dump_sum_q  <= sum_d;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end

        S_HOLD: begin
          // word held stable until the consumer takes it
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q     <= S_DONE;
              dump_done_q <= 1'b1;
              bus_req_q   <= 1'b0;
            end else begin
              idx_q   <= idx_d;
              state_q <= S_LOAD;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          bus_req_q   <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Bench for regfile_dbg_master: register-file model, write vector table, dump sequences.
// Inputs driven 1 time unit after the rising edge, outputs sampled 2 units after it.
// Grant/ready patterns are directed; expectations come from the bench's own register image.
module tb_regfile_dbg_master;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_dbg_master_if #(.AW(AW), .DW(DW)) bus ();

  regfile_dbg_master #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // register-file model: combinational read, write on the rising edge
  logic [DW-1:0] rf     [DEPTH];
  logic [DW-1:0] exp_rf [DEPTH];
  logic          preload_go = 1'b0;

  assign bus.rs1_data = rf[bus.rs1_address];

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= 32'h0101_0101 * 32'(i);
    end else if (bus.chip_en && bus.write_enable && bus.wr_port_add != '0) begin
      rf[bus.wr_port_add] <= bus.wr_port_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_req"},      32'(bus.bus_req), 0);
    chk({tag, "_chip_en"},      32'(bus.chip_en), 0);
    chk({tag, "_write_enable"}, 32'(bus.write_enable), 0);
    chk({tag, "_wr_port_add"},  32'(bus.wr_port_add), 0);
    chk({tag, "_wr_port_data"}, bus.wr_port_data, 0);
    chk({tag, "_rs1_address"},  32'(bus.rs1_address), 0);
    chk({tag, "_wr_ack"},       32'(bus.wr_ack), 0);
    chk({tag, "_wr_err"},       32'(bus.wr_err), 0);
    chk({tag, "_out_valid"},    32'(bus.out_valid), 0);
    chk({tag, "_out_addr"},     32'(bus.out_addr), 0);
    chk({tag, "_out_data"},     bus.out_data, 0);
    chk({tag, "_dump_done"},    32'(bus.dump_done), 0);
    chk({tag, "_dump_sum"},     bus.dump_sum, 0);
    chk({tag, "_busy"},         32'(bus.busy), 0);
  endtask

  // load the register-file model with xN = N*0x01010101 and mirror it in the expected image
  task automatic preload();
    @(posedge clk); #1;
    preload_go = 1'b1;
    @(posedge clk); #1;
    preload_go = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_rf[i] = 32'h0101_0101 * 32'(i);
  endtask

  // one dump: optional toggling ready, optional 5-cycle grant loss starting at cycle drop_at
  task automatic run_dump(input string tag, input bit toggle, input int drop_at);
    logic [31:0]   pattern;
    logic [31:0]   exp_sum;
    logic          pv, pr;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    int nwords, first_valid, done_cnt, done_cyc, last_hs;
    int order_bad, data_bad, stable_bad, ce_bad;
    pattern = 32'b1011_0010_0110_1110_1001_1100_0101_1011;
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) exp_sum = exp_sum ^ exp_rf[i];
    nwords = 0; first_valid = -1; done_cnt = 0; done_cyc = -1; last_hs = -1;
    order_bad = 0; data_bad = 0; stable_bad = 0; ce_bad = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;

    @(posedge clk); #1;
    bus.cmd_dump  = 1'b1;
    bus.bus_gnt   = 1'b1;
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      bus.cmd_dump  = 1'b0;
      bus.out_ready = toggle ? pattern[c % 32] : 1'b1;
      bus.bus_gnt   = !(drop_at > 0 && c >= drop_at && c < drop_at + 5);
      #1;
      if (!bus.bus_gnt && (bus.chip_en || bus.write_enable)) ce_bad++;
      if (pv && !pr) begin
        if (!bus.out_valid || bus.out_data !== pd || bus.out_addr !== pa) stable_bad++;
      end
      if (bus.out_valid && first_valid < 0) first_valid = c;
      if (bus.out_valid && bus.out_ready) begin
        if (nwords >= DEPTH || 32'(bus.out_addr) != nwords) order_bad++;
        else if (bus.out_data !== exp_rf[nwords]) data_bad++;
        nwords++;
        last_hs = c;
      end
      if (bus.dump_done) begin
        done_cnt++;
        done_cyc = c;
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pa = bus.out_addr;
    end
    bus.bus_gnt = 1'b1;

    chk({tag, "_first_valid_cycle"}, 32'(first_valid), 3);
    chk({tag, "_word_count"},        32'(nwords), DEPTH);
    chk({tag, "_order_errors"},      32'(order_bad), 0);
    chk({tag, "_data_errors"},       32'(data_bad), 0);
    chk({tag, "_stability_errors"},  32'(stable_bad), 0);
    chk({tag, "_chip_en_ungranted"}, 32'(ce_bad), 0);
    chk({tag, "_done_pulses"},       32'(done_cnt), 1);
    chk({tag, "_done_after_last"},   32'(done_cyc), 32'(last_hs + 1));
    chk({tag, "_dump_sum"},          bus.dump_sum, exp_sum);
    chk({tag, "_busy_end"},          32'(bus.busy), 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          also_dump;
    int            exp_we;
    logic          exp_err;
  } wvec_t;

  localparam int NWV = 6;
  wvec_t wv [NWV];

  initial begin
    int found;
    int done_seen;

    bus.bus_gnt     = 1'b0;
    bus.cmd_wr      = 1'b0;
    bus.cmd_wr_addr = '0;
    bus.cmd_wr_data = '0;
    bus.cmd_dump    = 1'b0;
    bus.out_ready   = 1'b0;

    wv[0] = '{addr: 5'd5,  data: 32'hDEAD_BEEF, also_dump: 1'b0, exp_we: 1, exp_err: 1'b0};
    wv[1] = '{addr: 5'd0,  data: 32'h1234_5678, also_dump: 1'b0, exp_we: 0, exp_err: 1'b1};
    wv[2] = '{addr: 5'd31, data: 32'hA5A5_0F0F, also_dump: 1'b0, exp_we: 1, exp_err: 1'b0};
    wv[3] = '{addr: 5'd1,  data: 32'h0000_0001, also_dump: 1'b0, exp_we: 1, exp_err: 1'b0};
    wv[4] = '{addr: 5'd7,  data: 32'hCAFE_F00D, also_dump: 1'b1, exp_we: 1, exp_err: 1'b0};
    wv[5] = '{addr: 5'd0,  data: 32'hFFFF_FFFF, also_dump: 1'b1, exp_we: 0, exp_err: 1'b1};

    // reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    preload();

    // write vectors with grant held high
    bus.bus_gnt = 1'b1;
    for (int v = 0; v < NWV; v++) begin
      int ack_cyc, ack_cnt, we_cnt, we_bad, busy_cnt, valid_seen;
      logic err_at_ack;
      ack_cyc = -1; ack_cnt = 0; we_cnt = 0; we_bad = 0; busy_cnt = 0; valid_seen = 0;
      err_at_ack = 1'bx;
      @(posedge clk); #1;
      bus.cmd_wr      = 1'b1;
      bus.cmd_wr_addr = wv[v].addr;
      bus.cmd_wr_data = wv[v].data;
      bus.cmd_dump    = wv[v].also_dump;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        bus.cmd_wr   = 1'b0;
        bus.cmd_dump = 1'b0;
        #1;
        if (bus.write_enable) begin
          we_cnt++;
          if (bus.wr_port_add !== wv[v].addr || bus.wr_port_data !== wv[v].data) we_bad++;
        end
        if (bus.wr_ack) begin
          ack_cnt++;
          ack_cyc    = c;
          err_at_ack = bus.wr_err;
        end
        if (bus.busy) busy_cnt++;
        if (bus.out_valid) valid_seen++;
      end
      if (wv[v].addr != '0) exp_rf[wv[v].addr] = wv[v].data;
      chk($sformatf("wr%0d_ack_cycle", v), 32'(ack_cyc), 3);
      chk($sformatf("wr%0d_ack_pulses", v), 32'(ack_cnt), 1);
      chk($sformatf("wr%0d_err", v), 32'(err_at_ack), 32'(wv[v].exp_err));
      chk($sformatf("wr%0d_we_cycles", v), 32'(we_cnt), 32'(wv[v].exp_we));
      chk($sformatf("wr%0d_we_addr_data", v), 32'(we_bad), 0);
      chk($sformatf("wr%0d_busy_cycles", v), 32'(busy_cnt), 3);
      chk($sformatf("wr%0d_no_out_valid", v), 32'(valid_seen), 0);
      chk($sformatf("wr%0d_rf_value", v), rf[wv[v].addr], exp_rf[wv[v].addr]);
    end

    // full dump of the preloaded file, ready held high
    preload();
    run_dump("dump_ready", 1'b0, 0);

    // dump with toggling ready and a 5-cycle grant loss mid-dump
    run_dump("dump_toggle", 1'b1, 20);

    // reset while word 10 is on the stream
    found = 0;
    @(posedge clk); #1;
    bus.cmd_dump  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 100 && found == 0; c++) begin
      @(posedge clk); #1;
      bus.cmd_dump = 1'b0;
      #1;
      if (bus.out_valid && bus.out_addr == 5'd10) found = 1;
    end
    chk("rst_mid_reached_addr10", 32'(found), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      if (bus.dump_done || bus.out_valid) done_seen++;
    end
    chk("rst_mid_no_done_after", 32'(done_seen), 0);
    chk("rst_mid_idle_after", 32'(bus.busy), 0);

    // fresh dump after the aborted one restarts at x0
    run_dump("dump_after_rst", 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dbg_master.md
# regfile_dbg_master

Debug-side initiator for the RV32I register file's read and write ports. It arbitrates for the register-file ports through a request/grant pair and executes single-register writes from the debug host. It also executes full-file dumps that sweep x0..x31 out over a valid/ready stream and finish with an XOR checksum. It sits between the debug transport and the register-file port mux, and drives the register file only while granted.

## Interface
- `DEPTH`, default 32: number of registers swept by a dump.
- `AW`, default 5: register address width.
- `DW`, default 32: register data width.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `bus_req` out 1: request ownership of the register-file ports.
- `bus_gnt` in 1: ownership granted; the port mux selects this block.
- `chip_en` out 1: register-file enable.
- `write_enable` out 1: register-file write strobe.
- `wr_port_add` out AW: write address.
- `wr_port_data` out DW: write data.
- `rs1_address` out AW: read address.
- `rs1_data` in DW: combinational read data for `rs1_address`.
- `cmd_wr` in 1: write command pulse.
- `cmd_wr_addr` in AW: target register for `cmd_wr`.
- `cmd_wr_data` in DW: write value for `cmd_wr`.
- `wr_ack` out 1: one-cycle completion pulse for a write command.
- `wr_err` out 1: valid with `wr_ack`; 1 means the write targeted x0 and was dropped.
- `cmd_dump` in 1: dump command pulse.
- `out_valid` out 1: dump word valid.
- `out_ready` in 1: consumer ready.
- `out_addr` out AW: register index of `out_data`.
- `out_data` out DW: dumped register value.
- `dump_done` out 1: one-cycle pulse after the last dump handshake.
- `dump_sum` out DW: XOR of all dumped words; held until the next dump starts.
- `busy` out 1: block is not in IDLE.

## Operation
- FSM states: IDLE, REQ, WRITE, ACK, LOAD, HOLD, DONE.
- IDLE:
  - `cmd_wr` latches address and data, then goes to REQ with `op=WR`.
  - Else `cmd_dump` clears the index and `dump_sum`, then goes to REQ with `op=DUMP`.
  - If both are asserted in the same cycle, the write wins and the dump is dropped.
  - Commands arriving while `busy`=1 are ignored.
- REQ: `bus_req`=1. Wait for `bus_gnt`. Then go to WRITE if `op=WR`, else LOAD.
- WRITE: lasts exactly one cycle.
  - `chip_en`=1, `write_enable`=(addr!=0), with `wr_port_add` and `wr_port_data` driven from the latches.
  - Next state is ACK.
- ACK:
  - `wr_ack`=1 and `wr_err`=(addr==0).
  - `bus_req` drops.
  - Next state is IDLE.
- LOAD:
  - `chip_en`=1, `write_enable`=0, `rs1_address`=index.
  - At the clock edge: `out_data`<=`rs1_data`, `out_addr`<=index, `dump_sum`<=`dump_sum`^`rs1_data`, `out_valid`<=1.
  - Next state is HOLD.
  - If `bus_gnt`=0 in LOAD, stay in LOAD with no capture and no checksum update.
- HOLD:
  - `out_valid`=1 and `out_data`/`out_addr` are stable until `out_valid`&&`out_ready`.
  - On handshake: if index==DEPTH-1 go to DONE; else index+1 and go to LOAD.
  - `bus_req` stays high throughout the dump.
- DONE:
  - `dump_done`=1 for one cycle and `bus_req` drops.
  - `dump_sum` is final.
  - Next state is IDLE.
- `write_enable` is never asserted unless `bus_gnt`=1 in that cycle. In WRITE, a lost grant holds the state without strobing until the grant returns.
- `chip_en` is asserted only in WRITE/LOAD with `bus_gnt`=1.
- The index is AW bits wide and never wraps past DEPTH-1.

## Timing
- Reset (`rst`=0):
  - Asynchronous return to IDLE.
  - All outputs are 0, including `dump_sum`, `out_data`, `out_addr`, `bus_req`, `chip_en`, and `write_enable`.
  - All latches and the index clear.
  - Reset mid-operation aborts the operation with no `wr_ack` or `dump_done`.
- Write latency, with `bus_gnt` already high: `cmd_wr` at cycle 0, REQ at 1, WRITE at 2 (register file updates at the end of 2), `wr_ack` at 3, IDLE at 4.
- Dump: the first `out_valid` appears 3 cycles after `cmd_dump` with immediate grant.
- Dump throughput is one word per 2 cycles with `out_ready` held high. 32 words take 64 cycles plus overhead.
- `dump_done` is asserted in the cycle after the final handshake.
- `busy`=1 in every state except IDLE.

## Test plan
- Write x5=0xDEADBEEF with grant held high:
  - `write_enable`=1 in exactly one cycle with `wr_port_add`=5.
  - `wr_ack`=1 and `wr_err`=0 three cycles after `cmd_wr`.
  - The register-file model shows x5=0xDEADBEEF.
- Write x0=0x12345678:
  - `write_enable` is never asserted.
  - `wr_ack`=1 and `wr_err`=1.
- Dump with registers preloaded xN=N*0x01010101 and `out_ready`=1:
  - 32 words arrive with `out_addr` 0..31 in order.
  - `dump_sum` equals the XOR of the preloaded values.
  - `dump_done` pulses once.
- Dump with `out_ready` toggling in a random pattern and `bus_gnt` dropped for 5 cycles mid-dump:
  - No word is lost or duplicated.
  - `out_data` is stable while `out_valid`&&!`out_ready`.
  - `chip_en`=0 while ungranted.
- `cmd_wr` and `cmd_dump` asserted in the same cycle:
  - The write completes.
  - No `out_valid` appears.
  - `busy` returns to 0.
- `rst` asserted during the dump at `out_addr`=10:
  - All outputs are 0 immediately.
  - No `dump_done` is produced.
  - A subsequent `cmd_dump` restarts from index 0.
